// File: rtl/mem_stage_ctrl.sv
// MEM-stage load/store sequencer: issues one data-memory access per EX/MEM instruction and stalls the pipeline until it completes.
// Optional define MEM_TIMEOUT_EN aborts an access after TIMEOUT_CYCLES BUSY cycles without dmem_ready.
module mem_stage_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        access_err,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_next;
    logic        access_pending;
    logic        size_ok;
    logic        align_ok;
    logic        legal;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [1:0]  offset_q;
    logic [2:0]  funct3_q;
    logic        timed_out;
    logic [31:0] lane;
    logic [31:0] load_ext;

    // Decode access size into alignment, byte enables and lane-replicated store data.
    always_comb begin
        size_ok    = 1'b0;
        align_ok   = 1'b0;
        be_calc    = 4'b0000;
        wdata_calc = wdata;
        case (funct3)
            3'b000, 3'b100: begin
                size_ok    = 1'b1;
                align_ok   = 1'b1;
                be_calc    = 4'b0001 << addr[1:0];
                wdata_calc = {4{wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                size_ok    = 1'b1;
                align_ok   = ~addr[0];
                be_calc    = 4'b0011 << {addr[1], 1'b0};
                wdata_calc = {2{wdata[15:0]}};
            end
            3'b010: begin
                size_ok    = 1'b1;
                align_ok   = (addr[1:0] == 2'b00);
                be_calc    = 4'b1111;
            end
            default: ;
        endcase
    end

    assign access_pending = mem_read | mem_write;
    assign legal = (mem_read ^ mem_write) && size_ok && align_ok && !(mem_write && funct3[2]);
    assign dmem_req = (state == BUSY);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] busy_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_cnt <= '0;
        end else if (state != BUSY) begin
            busy_cnt <= '0;
        end else if (!dmem_ready) begin
            busy_cnt <= busy_cnt + 1'b1;
        end
    end

    assign timed_out = (state == BUSY) && !dmem_ready && (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timed_out;
        end
    end
`else
    assign timed_out   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs are gated by reset so a held instruction cannot stall or flag an error while reset is asserted.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        access_err = 1'b0;
        case (state)
            IDLE: begin
                if (legal) begin
                    state_next = BUSY;
                    stall      = 1'b1;
                end else if (access_pending) begin
                    access_err = 1'b1;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (dmem_ready || timed_out) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (reset) begin
            stall      = 1'b0;
            access_err = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= 4'b0000;
            dmem_wdata <= '0;
            offset_q   <= 2'b00;
            funct3_q   <= 3'b000;
        end else if (state == IDLE && legal) begin
            dmem_we    <= mem_write;
            dmem_addr  <= {addr[31:2], 2'b00};
            dmem_be    <= be_calc;
            dmem_wdata <= wdata_calc;
            offset_q   <= addr[1:0];
            funct3_q   <= funct3;
        end
    end

    // Word loads are always aligned, so the shifted lane equals the full read word for them.
    always_comb begin
        lane = dmem_rdata >> {offset_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {24'b0, lane[7:0]};
            3'b101:  load_ext = {16'b0, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_data  <= '0;
            load_valid <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            if (state == BUSY && !dmem_we) begin
                if (dmem_ready) begin
                    load_data  <= load_ext;
                    load_valid <= 1'b1;
                end else if (timed_out) begin
                    load_data <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus randomized accesses against a byte-level reference model.
// The timeout scenario is built only when MEM_TIMEOUT_EN is defined.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  funct3 = 3'b000;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        access_err;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    int          obs_stall, obs_req, obs_to;
    bit          obs_lv, obs_ae, obs_done;
    logic [31:0] obs_addr, obs_wdata, obs_ld, obs_ld_end;
    logic [3:0]  obs_be;
    logic        obs_we;
    logic [31:0] model_load_data = '0;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .wdata      (wdata),
        .funct3     (funct3),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .access_err (access_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Access size in bytes, 0 for an undefined encoding.
    function automatic int model_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit model_legal(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
        int size = model_size(f3);
        if (rd == wr || size == 0) return 0;
        if (wr && f3 >= 3'd4) return 0;
        return (int'(a % 32'd4) % size) == 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int size = model_size(f3);
        int mask = (1 << size) - 1;
        return 4'(mask << int'(a % 32'd4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int size = model_size(f3);
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % size) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int size = model_size(f3);
        logic [31:0] mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
        logic [31:0] v = (rd >> (8 * int'(a % 32'd4))) & mask;
        if (f3 < 3'd4 && size < 4 && v[8*size-1]) v = v | ~mask;
        return v;
    endfunction

    // Presents one EX/MEM instruction, plays the memory with the given wait count and holds the instruction until an unstalled cycle.
    task automatic run_access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                              input logic [2:0] f3, input logic [31:0] rdata, input int waits);
        int cycles = 0;
        obs_stall = 0; obs_req = 0; obs_to = 0;
        obs_lv = 0; obs_ae = 0; obs_done = 0;
        obs_addr = '0; obs_wdata = '0; obs_be = '0; obs_we = 1'b0; obs_ld = '0; obs_ld_end = '0;
        mem_read = rd; mem_write = wr; addr = a; wdata = wd; funct3 = f3;
        while (!obs_done && cycles < 64) begin
            #1;
            if (dmem_req) begin
                if (obs_req == 0) begin
                    obs_addr = dmem_addr; obs_be = dmem_be; obs_wdata = dmem_wdata; obs_we = dmem_we;
                end
                if (obs_req == waits) begin
                    dmem_ready = 1'b1;
                    dmem_rdata = rdata;
                end
                obs_req++;
            end
            if (stall) obs_stall++; else obs_done = 1;
            if (load_valid) begin obs_lv = 1; obs_ld = load_data; end
            if (access_err) obs_ae = 1;
            if (timeout_err) obs_to++;
            obs_ld_end = load_data;
            @(posedge clk);
            @(negedge clk);
            dmem_ready = 1'b0;
            dmem_rdata = $urandom;
            cycles++;
        end
        mem_read = 1'b0; mem_write = 1'b0;
        checks++;
        if (!obs_done) begin
            errors++;
            $display("[TB] FAIL access_bound: stall never released after %0d cycles, required release", cycles);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b required 0", dmem_req); end
        checks++; if (dmem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b required 0", dmem_we); end
        checks++; if (dmem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h required 0", dmem_addr); end
        checks++; if (dmem_be !== 4'h0) begin errors++; $display("[TB] FAIL reset_be: got %b required 0000", dmem_be); end
        checks++; if (dmem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_wdata: got %h required 0", dmem_wdata); end
        checks++; if (load_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_load_data: got %h required 0", load_data); end
        checks++; if ({load_valid, access_err, timeout_err, stall} !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_pulses: got %b required 0000", {load_valid, access_err, timeout_err, stall});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        checks++; if ({dmem_req, stall} !== 2'b00) begin errors++; $display("[TB] FAIL post_reset_idle: got %b required 00", {dmem_req, stall}); end
        @(negedge clk);
    endtask

    task automatic test_load_word();
        run_access(1, 0, 32'h100, 32'h0, 3'b010, 32'hDEAD_BEEF, 0);
        checks++; if (obs_addr !== 32'h100) begin errors++; $display("[TB] FAIL lw_addr: got %h required 00000100", obs_addr); end
        checks++; if (obs_be !== 4'b1111) begin errors++; $display("[TB] FAIL lw_be: got %b required 1111", obs_be); end
        checks++; if (obs_stall !== 2) begin errors++; $display("[TB] FAIL lw_stall: got %0d required 2", obs_stall); end
        checks++; if (obs_req !== 1) begin errors++; $display("[TB] FAIL lw_req_cycles: got %0d required 1", obs_req); end
        checks++; if (obs_lv !== 1'b1 || obs_ld !== 32'hDEAD_BEEF) begin
            errors++; $display("[TB] FAIL lw_data: got valid %b data %h required 1 deadbeef", obs_lv, obs_ld);
        end
        model_load_data = 32'hDEAD_BEEF;
    endtask

    task automatic test_load_byte();
        run_access(1, 0, 32'h103, 32'h0, 3'b000, 32'h80FF_0000, 0);
        checks++; if (obs_be !== 4'b1000) begin errors++; $display("[TB] FAIL lb_be: got %b required 1000", obs_be); end
        checks++; if (obs_ld !== 32'hFFFF_FF80) begin errors++; $display("[TB] FAIL lb_data: got %h required ffffff80", obs_ld); end
        run_access(1, 0, 32'h103, 32'h0, 3'b100, 32'h80FF_0000, 1);
        checks++; if (obs_ld !== 32'h0000_0080) begin errors++; $display("[TB] FAIL lbu_data: got %h required 00000080", obs_ld); end
        checks++; if (obs_stall !== 3) begin errors++; $display("[TB] FAIL lbu_stall: got %0d required 3", obs_stall); end
        model_load_data = 32'h0000_0080;
    endtask

    task automatic test_store_half();
        run_access(0, 1, 32'h202, 32'h0000_ABCD, 3'b001, 32'h1234_5678, 3);
        checks++; if (obs_be !== 4'b1100) begin errors++; $display("[TB] FAIL sh_be: got %b required 1100", obs_be); end
        checks++; if (obs_wdata !== 32'hABCD_ABCD) begin errors++; $display("[TB] FAIL sh_wdata: got %h required abcdabcd", obs_wdata); end
        checks++; if (obs_we !== 1'b1) begin errors++; $display("[TB] FAIL sh_we: got %b required 1", obs_we); end
        checks++; if (obs_addr !== 32'h200) begin errors++; $display("[TB] FAIL sh_addr: got %h required 00000200", obs_addr); end
        checks++; if (obs_stall !== 5) begin errors++; $display("[TB] FAIL sh_stall: got %0d required 5", obs_stall); end
        checks++; if (obs_lv !== 1'b0 || obs_ld_end !== model_load_data) begin
            errors++; $display("[TB] FAIL sh_no_load: got valid %b data %h required 0 %h", obs_lv, obs_ld_end, model_load_data);
        end
    endtask

    task automatic test_misaligned();
        run_access(1, 0, 32'h101, 32'h0, 3'b010, 32'hFFFF_FFFF, 0);
        checks++; if (obs_ae !== 1'b1) begin errors++; $display("[TB] FAIL misaligned_err: got %b required 1", obs_ae); end
        checks++; if (obs_stall !== 0 || obs_req !== 0) begin
            errors++; $display("[TB] FAIL misaligned_quiet: got stall %0d req %0d required 0 0", obs_stall, obs_req);
        end
        run_access(1, 1, 32'h100, 32'h0, 3'b010, 32'h0, 0);
        checks++; if (obs_ae !== 1'b1 || obs_req !== 0) begin
            errors++; $display("[TB] FAIL rw_both_err: got err %b req %0d required 1 0", obs_ae, obs_req);
        end
    endtask

    task automatic test_ready_outside_busy();
        bit seen = 0;
        for (int i = 0; i < 3; i++) begin
            dmem_ready = 1'b1;
            dmem_rdata = $urandom;
            #1;
            if (load_valid || stall || dmem_req) seen = 1;
            @(posedge clk);
            @(negedge clk);
        end
        dmem_ready = 1'b0;
        #1;
        checks++; if (seen !== 1'b0 || load_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL idle_ready: got activity %b valid %b required 0 0", seen, load_valid);
        end
        checks++; if (load_data !== model_load_data) begin
            errors++; $display("[TB] FAIL idle_ready_data: got %h required %h", load_data, model_load_data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_busy();
        bit seen_lv = 0;
        mem_read = 1'b1; addr = 32'h300; funct3 = 3'b010;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL rib_busy: got req %b required 1", dmem_req); end
        reset = 1'b1;
        #1;
        checks++; if ({dmem_req, stall} !== 2'b00) begin
            errors++; $display("[TB] FAIL rib_drop: got req/stall %b required 00", {dmem_req, stall});
        end
        mem_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dmem_ready = 1'b1;
            dmem_rdata = $urandom;
            #1;
            if (load_valid) seen_lv = 1;
            @(negedge clk);
        end
        dmem_ready = 1'b0;
        model_load_data = '0;
        checks++; if (seen_lv !== 1'b0) begin errors++; $display("[TB] FAIL rib_no_valid: got %b required 0", seen_lv); end
        checks++; if (load_data !== 32'h0) begin errors++; $display("[TB] FAIL rib_load_data: got %h required 0", load_data); end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        run_access(1, 0, 32'h40, 32'h0, 3'b010, 32'h5555_AAAA, 0);
        run_access(1, 0, 32'h44, 32'h0, 3'b010, 32'h0, 1000);
        checks++; if (obs_req !== 4) begin errors++; $display("[TB] FAIL to_req_cycles: got %0d required 4", obs_req); end
        checks++; if (obs_to !== 1) begin errors++; $display("[TB] FAIL to_err: got %0d pulses required 1", obs_to); end
        checks++; if (obs_lv !== 1'b0 || obs_ld_end !== 32'h0) begin
            errors++; $display("[TB] FAIL to_data: got valid %b data %h required 0 0", obs_lv, obs_ld_end);
        end
        checks++; if (obs_stall !== 5) begin errors++; $display("[TB] FAIL to_stall: got %0d required 5", obs_stall); end
        model_load_data = '0;
    endtask
`endif

    task automatic test_back_to_back();
        run_access(0, 1, 32'h7, 32'h0000_00C3, 3'b000, 32'h0, 0);
        checks++; if (obs_be !== 4'b1000 || obs_wdata !== 32'hC3C3_C3C3) begin
            errors++; $display("[TB] FAIL b2b_sb: got be %b wdata %h required 1000 c3c3c3c3", obs_be, obs_wdata);
        end
        run_access(1, 0, 32'h6, 32'h0, 3'b001, 32'h8001_7FFF, 0);
        checks++; if (obs_stall !== 2 || obs_ld !== 32'hFFFF_8001) begin
            errors++; $display("[TB] FAIL b2b_lh: got stall %0d data %h required 2 ffff8001", obs_stall, obs_ld);
        end
        model_load_data = 32'hFFFF_8001;
    endtask

    task automatic test_random();
        logic [2:0] f3_table [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  f3 = f3_table[$urandom_range(0, 7)];
            int          kind = $urandom_range(0, 9);
            bit          rd = (kind < 5) || (kind == 9);
            bit          wr = (kind >= 5);
            logic [31:0] a = $urandom;
            logic [31:0] wd = $urandom;
            logic [31:0] rdat = $urandom;
            int          waits = $urandom_range(0, 3);
            bit          ok = model_legal(rd, wr, f3, a);
            run_access(rd, wr, a, wd, f3, rdat, waits);
            if (!ok) begin
                checks++; if (obs_ae !== 1'b1 || obs_req !== 0 || obs_stall !== 0) begin
                    errors++; $display("[TB] FAIL rnd_illegal[%0d]: got err %b req %0d stall %0d required 1 0 0", n, obs_ae, obs_req, obs_stall);
                end
            end else begin
                checks++; if (obs_req !== waits + 1 || obs_stall !== waits + 2 || obs_ae !== 1'b0) begin
                    errors++; $display("[TB] FAIL rnd_timing[%0d]: got req %0d stall %0d err %b required %0d %0d 0", n, obs_req, obs_stall, obs_ae, waits + 1, waits + 2);
                end
                checks++; if (obs_addr !== {a[31:2], 2'b00} || obs_be !== model_be(f3, a) || obs_we !== wr) begin
                    errors++; $display("[TB] FAIL rnd_req[%0d]: got addr %h be %b we %b required %h %b %b", n, obs_addr, obs_be, obs_we, {a[31:2], 2'b00}, model_be(f3, a), wr);
                end
                if (wr) begin
                    checks++; if (obs_wdata !== model_wdata(f3, wd) || obs_lv !== 1'b0 || obs_ld_end !== model_load_data) begin
                        errors++; $display("[TB] FAIL rnd_store[%0d]: got wdata %h valid %b data %h required %h 0 %h", n, obs_wdata, obs_lv, obs_ld_end, model_wdata(f3, wd), model_load_data);
                    end
                end else begin
                    model_load_data = model_load(f3, a, rdat);
                    checks++; if (obs_lv !== 1'b1 || obs_ld !== model_load_data) begin
                        errors++; $display("[TB] FAIL rnd_load[%0d]: got valid %b data %h required 1 %h", n, obs_lv, obs_ld, model_load_data);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_ready_outside_busy();
        test_back_to_back();
        test_reset_in_busy();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
